serial_tx_scheduler: RTL and testbench
======================================

# serial_tx_scheduler

Round-robin scheduler that shares one N-bit parallel-to-serial shift register among R requesters. It arbitrates between pending words and captures the winner's word and shift direction. It then drives the shifter's load, direction and data inputs, and frames the N serial bits that appear on the shifter output. It sits between the requesting blocks and the single serializer instance.

## Interface
- N, 4: word width; must match the shifter width; N >= 2.
- R, 2: number of requesters, 2..8.
- GAP, 1: idle cycles inserted after each frame, 0..15.
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- req  in  R  per-requester request; held with data stable until granted.
- req_data  in  R*N  word for requester i in bits [i*N +: N].
- req_dir  in  R  direction for requester i: 0 = MSB_FIRST, 1 = LSB_FIRST.
- grant  out  R  one-hot acknowledge, one cycle wide.
- sh_load  out  1  to shifter valid/load input.
- sh_dir  out  1  to shifter direction input.
- sh_data  out  N  to shifter parallel data input.
- frame  out  1  high while the shifter output carries a valid bit.
- bit_idx  out  clog2(N)  index of the current bit within the frame, counting 0..N-1 in transmit order.
- done  out  1  one-cycle pulse on the last bit of a frame.
- busy  out  1  high in any state other than IDLE.

## Operation
- FSM states: IDLE, LOAD, SHIFT, GAP.
- **IDLE**
  - When req != 0 at a clock edge, select a winner w round-robin and go to LOAD.
  - At that edge, capture req_data[w] into the word register and req_dir[w] into the direction register.
- **Round-robin rule:** search starts at ptr, ptr+1, … mod R. After a grant to w, ptr = (w+1) mod R. Reset sets ptr = 0.
- **LOAD** (exactly 1 cycle)
  - grant[w] = 1, sh_load = 1, sh_data = captured word, sh_dir = captured direction.
  - Next state is SHIFT with the bit counter at 0.
- **SHIFT** (exactly N cycles)
  - sh_load = 0, frame = 1, bit_idx = counter.
  - On counter = N-1: done = 1, then go to GAP (GAP > 0) or IDLE (GAP = 0).
- **GAP** (exactly GAP cycles): all strobes 0, then IDLE.
- sh_dir is held at the captured direction from LOAD through the end of SHIFT, because the shifter output mux is combinational on direction. sh_dir changes only at a capture edge.
- sh_data holds the captured word; its value is don't-care outside LOAD, but it is driven from the register.
- Arbitration happens only in IDLE. A req that is still high after its grant is treated as a new request on the next IDLE.
- req changes during LOAD, SHIFT or GAP are ignored.

## Timing
- Reset values: state IDLE, ptr 0, grant 0, sh_load 0, sh_dir 0, sh_data 0, frame 0, bit_idx 0, done 0, busy 0.
- Reset asserted mid-frame:
  - Next cycle is IDLE with all outputs at reset values.
  - The shifter is reset by the same rst.
  - The interrupted word is dropped and is not re-granted automatically.
- Cycle-level sequence, with edge E0 sampling req in IDLE:
  - Cycle after E0: LOAD; grant and sh_load are high.
  - Edge E1: shifter loads.
  - Cycles E1..E1+N-1: SHIFT. The shifter output is bit bit_idx of the word: MSB first (bit N-1-k) or LSB first (bit k).
- Latency from req sampled to first valid bit is 2 cycles.
- Transaction period with continuous requests is N + GAP + 2 cycles.
- grant is never high for two consecutive cycles, and never for more than one requester at once.
- done coincides with the last cycle in which frame is high.
- busy is high in LOAD, SHIFT and GAP.

## Test plan
- **Single request, N=4, R=2, GAP=1.**
  - Stimulus: req=01, data0=4'b1011, dir0=MSB.
  - Required: grant=01 for 1 cycle; frame high 4 cycles; shifter out 1,0,1,1; bit_idx 0..3; done on the 4th frame cycle; busy low again after 7 cycles total (IDLE, LOAD, 4 SHIFT, 1 GAP).
- **LSB-first.**
  - Stimulus: req=01, data0=4'b1011, dir0=LSB.
  - Required: shifter out 1,1,0,1; sh_dir stays 1 through all SHIFT cycles.
- **Simultaneous requests.**
  - Stimulus: req=11 held continuously, data0=4'hA, data1=4'h5.
  - Required: grants alternate 01,10,01,10; serial words A,5,A,5; period 7 cycles.
- **Back-to-back with GAP=0.**
  - Required: done, then IDLE 1 cycle, then LOAD; period N+2 = 6 cycles; frame low for exactly 2 cycles between frames.
- **Reset mid-frame.**
  - Stimulus: rst for 1 cycle at bit_idx=2.
  - Required: next cycle all outputs 0 and state IDLE; ptr=0, so with req=11 requester 0 is granted first.
- **Request change during SHIFT.**
  - Stimulus: drop req and change data during SHIFT.
  - Required: the frame completes with the originally captured word; no extra grant.

Source files
------------

// File: rtl/serial_tx_scheduler_if.sv
// Request/shifter-control bundle between R requesters, the round-robin scheduler
// and the shared N-bit parallel-to-serial shifter.
interface serial_tx_scheduler_if #(
    parameter int N = 4,
    parameter int R = 2
);
    localparam int IDX_W = $clog2(N);

    logic [R-1:0]     req;
    logic [R*N-1:0]   req_data;
    logic [R-1:0]     req_dir;
    logic [R-1:0]     grant;
    logic             sh_load;
    logic             sh_dir;
    logic [N-1:0]     sh_data;
    logic             frame;
    logic [IDX_W-1:0] bit_idx;
    logic             done;
    logic             busy;

    // Requester side (drives requests, watches acknowledge and framing).
    modport master (
        output req, req_data, req_dir,
        input  grant, sh_load, sh_dir, sh_data, frame, bit_idx, done, busy
    );

    // Scheduler side.
    modport slave (
        input  req, req_data, req_dir,
        output grant, sh_load, sh_dir, sh_data, frame, bit_idx, done, busy
    );
endinterface

// File: rtl/serial_tx_scheduler.sv
// Round-robin arbiter that shares one N-bit parallel-to-serial shifter among R
// requesters: IDLE -> LOAD (1) -> SHIFT (N) -> GAP (GAP) -> IDLE.
module serial_tx_scheduler #(
    parameter int N   = 4,
    parameter int R   = 2,
    parameter int GAP = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    serial_tx_scheduler_if.slave bus
);
    localparam int IDX_W = $clog2(N);
    localparam int PTR_W = $clog2(R);
    localparam logic [IDX_W-1:0] BIT_LAST = IDX_W'(N - 1);
    localparam logic [3:0]       GAP_LAST = (GAP > 0) ? 4'(GAP - 1) : 4'd0;

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_SHIFT,
        S_GAP
    } state_t;

    state_t            state_q, state_d;
    logic [PTR_W-1:0]  ptr_q, ptr_d;
    logic [PTR_W-1:0]  win_q, win_d;
    logic [N-1:0]      word_q, word_d;
    logic              dir_q, dir_d;
    logic [IDX_W-1:0]  cnt_q, cnt_d;
    logic [3:0]        gap_q, gap_d;
    logic [PTR_W-1:0]  pick;
    logic [N-1:0]      words [R];

    for (genvar i = 0; i < R; i++) begin : g_words
        assign words[i] = bus.req_data[i*N +: N];
    end

    // First requester at or after p, wrapping modulo R.
    function automatic logic [PTR_W-1:0] rr_pick(input logic [R-1:0] r,
                                                  input logic [PTR_W-1:0] p);
        logic [PTR_W-1:0] w;
        logic             hit;
        int               idx;
        w   = p;
        hit = 1'b0;
        for (int k = 0; k < R; k++) begin
            idx = (int'(p) + k) % R;
            if (!hit && r[PTR_W'(idx)]) begin
                w   = PTR_W'(idx);
                hit = 1'b1;
            end
        end
        return w;
    endfunction

    function automatic logic [PTR_W-1:0] rr_next(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(R - 1)) ? '0 : p + 1'b1;
    endfunction

    assign pick = rr_pick(bus.req, ptr_q);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            ptr_q   <= '0;
            win_q   <= '0;
            word_q  <= '0;
            dir_q   <= 1'b0;
            cnt_q   <= '0;
            gap_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            win_q   <= win_d;
            word_q  <= word_d;
            dir_q   <= dir_d;
            cnt_q   <= cnt_d;
            gap_q   <= gap_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        win_d   = win_q;
        word_d  = word_q;
        dir_d   = dir_q;
        cnt_d   = cnt_q;
        gap_d   = gap_q;
        case (state_q)
            S_IDLE: begin
                // Arbitration and capture happen on the same edge; later req
                // changes cannot affect the frame in flight.
                if (|bus.req) begin
                    win_d   = pick;
                    ptr_d   = rr_next(pick);
                    word_d  = words[pick];
                    dir_d   = bus.req_dir[pick];
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                cnt_d   = '0;
                state_d = S_SHIFT;
            end
            S_SHIFT: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d   = '0;
                    gap_d   = '0;
                    state_d = (GAP > 0) ? S_GAP : S_IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_GAP: begin
                if (gap_q == GAP_LAST) begin
                    gap_d   = '0;
                    state_d = S_IDLE;
                end else begin
                    gap_d = gap_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Direction and word come straight from the capture registers so the
    // shifter's combinational output mux sees a stable direction all frame.
    assign bus.grant   = (state_q == S_LOAD) ? ({{(R-1){1'b0}}, 1'b1} << win_q) : '0;
    assign bus.sh_load = (state_q == S_LOAD);
    assign bus.sh_dir  = dir_q;
    assign bus.sh_data = word_q;
    assign bus.frame   = (state_q == S_SHIFT);
    assign bus.bit_idx = (state_q == S_SHIFT) ? cnt_q : '0;
    assign bus.done    = (state_q == S_SHIFT) && (cnt_q == BIT_LAST);
    assign bus.busy    = (state_q != S_IDLE);
endmodule

// File: tb/tb_serial_tx_scheduler.sv
// Directed plus randomized bench for serial_tx_scheduler with a behavioural
// shifter and a transaction-level round-robin model.
module tb_serial_tx_scheduler;
    localparam int N = 4;
    localparam int R = 2;

    logic           clk = 1'b0;
    logic           rst;
    logic [R-1:0]   req;
    logic [R*N-1:0] req_data;
    logic [R-1:0]   req_dir;
    logic           sel;

    int n_cmp = 0;
    int n_bad = 0;
    int mptr  = 0;

    always #5 clk = ~clk;

    serial_tx_scheduler_if #(.N(N), .R(R)) bus_a ();
    serial_tx_scheduler_if #(.N(N), .R(R)) bus_b ();

    assign bus_a.req      = req;
    assign bus_a.req_data = req_data;
    assign bus_a.req_dir  = req_dir;
    assign bus_b.req      = req;
    assign bus_b.req_data = req_data;
    assign bus_b.req_dir  = req_dir;

    serial_tx_scheduler #(.N(N), .R(R), .GAP(1)) dut_a (.clk(clk), .rst(rst), .bus(bus_a));
    serial_tx_scheduler #(.N(N), .R(R), .GAP(0)) dut_b (.clk(clk), .rst(rst), .bus(bus_b));

    // Shared shifter model: loads on sh_load, output mux follows live sh_dir.
    logic [N-1:0] shr_a, shr_b;
    always @(posedge clk) begin
        if (rst) shr_a <= '0;
        else if (bus_a.sh_load) shr_a <= bus_a.sh_data;
        else shr_a <= bus_a.sh_dir ? (shr_a >> 1) : (shr_a << 1);
    end
    always @(posedge clk) begin
        if (rst) shr_b <= '0;
        else if (bus_b.sh_load) shr_b <= bus_b.sh_data;
        else shr_b <= bus_b.sh_dir ? (shr_b >> 1) : (shr_b << 1);
    end

    logic [R-1:0] o_grant;
    logic         o_load, o_dir, o_frame, o_done, o_busy, o_ser;
    logic [N-1:0] o_data;
    logic [1:0]   o_idx;
    assign o_grant = sel ? bus_b.grant   : bus_a.grant;
    assign o_load  = sel ? bus_b.sh_load : bus_a.sh_load;
    assign o_dir   = sel ? bus_b.sh_dir  : bus_a.sh_dir;
    assign o_data  = sel ? bus_b.sh_data : bus_a.sh_data;
    assign o_frame = sel ? bus_b.frame   : bus_a.frame;
    assign o_idx   = sel ? bus_b.bit_idx : bus_a.bit_idx;
    assign o_done  = sel ? bus_b.done    : bus_a.done;
    assign o_busy  = sel ? bus_b.busy    : bus_a.busy;
    assign o_ser   = sel ? (bus_b.sh_dir ? shr_b[0] : shr_b[N-1])
                         : (bus_a.sh_dir ? shr_a[0] : shr_a[N-1]);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int model_pick(input logic [R-1:0] r, input int p);
        for (int k = 0; k < R; k++) begin
            if (r[(p + k) % R]) return (p + k) % R;
        end
        return -1;
    endfunction

    task automatic chk_all_zero(input string tag);
        chk({tag, "_grant"}, o_grant, 0);
        chk({tag, "_load"},  o_load,  0);
        chk({tag, "_dir"},   o_dir,   0);
        chk({tag, "_data"},  o_data,  0);
        chk({tag, "_frame"}, o_frame, 0);
        chk({tag, "_idx"},   o_idx,   0);
        chk({tag, "_done"},  o_done,  0);
        chk({tag, "_busy"},  o_busy,  0);
    endtask

    // Entered at a falling edge with the DUT in IDLE and req != 0; returns at
    // the falling edge of the IDLE cycle that follows the frame and its gap.
    task automatic run_frame(input int gap, input int perturb, output logic [N-1:0] seq);
        logic [N-1:0] word;
        logic [R-1:0] exp_g;
        logic         d;
        logic         exp_bit;
        int           w;
        w     = model_pick(req, mptr);
        mptr  = (w + 1) % R;
        word  = req_data[w*N +: N];
        d     = req_dir[w];
        exp_g = '0;
        exp_g[w] = 1'b1;
        seq   = '0;
        @(negedge clk);
        chk("load_grant", o_grant, exp_g);
        chk("load_strobe", o_load, 1);
        chk("load_data", o_data, word);
        chk("load_dir", o_dir, d);
        chk("load_busy", o_busy, 1);
        chk("load_frame", o_frame, 0);
        if (perturb == 1) begin
            req      = '0;
            req_data = ~req_data;
            req_dir  = ~req_dir;
        end else if (perturb == 2) begin
            req      = R'($urandom);
            req_data = (R*N)'($urandom);
            req_dir  = R'($urandom);
        end
        for (int k = 0; k < N; k++) begin
            @(negedge clk);
            exp_bit = d ? word[k] : word[N-1-k];
            chk("shift_frame", o_frame, 1);
            chk("shift_idx", o_idx, k);
            chk("shift_bit", o_ser, exp_bit);
            chk("shift_done", o_done, (k == N-1));
            chk("shift_grant", o_grant, 0);
            chk("shift_load", o_load, 0);
            chk("shift_dir", o_dir, d);
            chk("shift_busy", o_busy, 1);
            seq[N-1-k] = o_ser;
        end
        for (int g = 0; g < gap; g++) begin
            @(negedge clk);
            chk("gap_frame", o_frame, 0);
            chk("gap_busy", o_busy, 1);
            chk("gap_grant", o_grant, 0);
            chk("gap_done", o_done, 0);
        end
        @(negedge clk);
        chk("idle_busy", o_busy, 0);
        chk("idle_grant", o_grant, 0);
        chk("idle_frame", o_frame, 0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req = '0;
        @(negedge clk);
        @(negedge clk);
        rst  = 1'b0;
        mptr = 0;
    endtask

    initial begin
        logic [N-1:0] seq;
        rst = 1'b1; req = '0; req_data = '0; req_dir = '0; sel = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk_all_zero("reset");
        rst = 1'b0;
        @(negedge clk);

        // Single MSB-first request.
        req = 2'b01; req_data = 8'h0B; req_dir = 2'b00;
        run_frame(1, 0, seq);
        chk("msb_seq", seq, 4'b1011);
        req = '0;
        @(negedge clk);
        chk("msb_after_busy", o_busy, 0);

        // Same word LSB-first.
        req = 2'b01; req_data = 8'h0B; req_dir = 2'b01;
        run_frame(1, 0, seq);
        chk("lsb_seq", seq, 4'b1101);
        req = '0;

        // Both requesting continuously: alternate starting with requester 0.
        do_reset();
        req = 2'b11; req_data = 8'h5A; req_dir = 2'b00;
        for (int i = 0; i < 4; i++) begin
            run_frame(1, 0, seq);
            chk("rr_seq", seq, (i % 2 == 0) ? 4'hA : 4'h5);
        end
        req = '0;

        // Zero-gap instance: back-to-back frames.
        do_reset();
        sel = 1'b1;
        req = 2'b11; req_data = 8'h5A; req_dir = 2'b10;
        for (int i = 0; i < 3; i++) begin
            run_frame(0, 0, seq);
            chk("gap0_seq", seq, (i % 2 == 0) ? 4'hA : 4'hA);
        end
        req = '0;
        sel = 1'b0;
        do_reset();

        // Reset asserted at bit_idx 2 drops the frame; pointer restarts at 0.
        req = 2'b11; req_data = 8'h3C; req_dir = 2'b00;
        mptr = 1;
        @(negedge clk);
        chk("mid_grant", o_grant, 2'b01);
        for (int k = 0; k < 3; k++) @(negedge clk);
        chk("mid_idx", o_idx, 2);
        rst = 1'b1;
        @(negedge clk);
        chk_all_zero("mid_rst");
        rst  = 1'b0;
        mptr = 0;
        run_frame(1, 0, seq);
        chk("mid_after_seq", seq, 4'hC);
        req = '0;

        // Request dropped and data changed once captured.
        do_reset();
        req = 2'b01; req_data = 8'h06; req_dir = 2'b00;
        run_frame(1, 1, seq);
        chk("drop_seq", seq, 4'h6);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("drop_no_grant", o_grant, 0);
            chk("drop_idle", o_busy, 0);
        end

        // Randomized traffic on both instances.
        for (int s = 0; s < 2; s++) begin
            do_reset();
            sel = (s == 1);
            for (int i = 0; i < 30; i++) begin
                req      = R'($urandom_range(0, 3));
                req_data = (R*N)'($urandom);
                req_dir  = R'($urandom);
                if (req == '0) begin
                    @(negedge clk);
                    chk("rand_idle_busy", o_busy, 0);
                    chk("rand_idle_grant", o_grant, 0);
                end else begin
                    run_frame(sel ? 0 : 1, 2, seq);
                end
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
